// File: rtl/vram_blit_pkg.sv
// Shared definitions for the VRAM tile blitter: source encodings, FSM states,
// command register field positions and tile geometry.
package vram_blit_pkg;

  localparam int unsigned TILE_DIM = 32;
  localparam int unsigned TILE_PIX = TILE_DIM * TILE_DIM;
  localparam int unsigned PIX_W    = 12;
  localparam int unsigned COORD_W  = 9;
  localparam int unsigned VADDR_W  = 2 * COORD_W;
  localparam int unsigned ROM_AW   = 10;
  localparam int unsigned CNT_W    = 11;

  // Command register field positions
  localparam int unsigned CFG_SRC_HI = 31;
  localparam int unsigned CFG_SRC_LO = 30;
  localparam int unsigned CFG_TRANS  = 29;
  localparam int unsigned CFG_ABORT  = 28;
  localparam int unsigned CFG_DY_HI  = 17;
  localparam int unsigned CFG_DY_LO  = 9;
  localparam int unsigned CFG_DX_HI  = 8;
  localparam int unsigned CFG_DX_LO  = 0;

  typedef enum logic [1:0] {
    SRC_BG   = 2'd0,
    SRC_CHAR = 2'd1,
    SRC_CI   = 2'd2,
    SRC_WALL = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } state_e;

endpackage

// File: rtl/vram_blit_ctrl.sv
// Tile blitter and VRAM write-port arbiter.
// Copies a 32x32 tile from one of four sprite ROMs into VRAM at (dx,dy),
// clipping off-screen pixels and optionally skipping a transparent key colour.
// CPU single-pixel writes share the VRAM port and always win.
// Ports:
//   clk, rst                  clock, async active-high reset
//   cfg_we, cfg_data          command register write
//   status, done              {busy, 20'b0, pix_cnt}; completion pulse
//   cpu_vram_we/addr/data     CPU pixel write request
//   rom_addr, *_data          shared ROM address, ROM read data (1-cycle latency)
//   vram_we/addr/data         registered VRAM write port
module vram_blit_ctrl
  import vram_blit_pkg::*;
#(
  parameter int unsigned SCREEN_W  = 512,
  parameter int unsigned SCREEN_H  = 480,
  parameter logic [11:0] TRANS_KEY = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [31:0] cfg_data,
  output logic [31:0] status,
  output logic        done,
  input  logic        cpu_vram_we,
  input  logic [17:0] cpu_vram_addr,
  input  logic [11:0] cpu_vram_data,
  output logic [9:0]  rom_addr,
  input  logic [11:0] background_data,
  input  logic [11:0] character_data,
  input  logic [11:0] ci_data,
  input  logic [11:0] wall_data,
  output logic        vram_we,
  output logic [17:0] vram_addr,
  output logic [11:0] vram_data
);

  localparam logic [9:0]       SCR_W_L  = 10'(SCREEN_W);
  localparam logic [9:0]       SCR_H_L  = 10'(SCREEN_H);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(TILE_PIX - 1);

  state_e               state;
  src_e                 src_q;
  logic                 trans_q;
  logic [COORD_W-1:0]   dx_q;
  logic [COORD_W-1:0]   dy_q;
  logic [CNT_W-1:0]     pix_cnt;
  logic                 busy_q;
  logic                 done_pend;

  // Command decode
  src_e               cmd_src;
  logic               cmd_trans;
  logic               cmd_abort;
  logic [COORD_W-1:0] cmd_dx;
  logic [COORD_W-1:0] cmd_dy;
  logic               cfg_unused;

  assign cmd_src    = src_e'(cfg_data[CFG_SRC_HI:CFG_SRC_LO]);
  assign cmd_trans  = cfg_data[CFG_TRANS];
  assign cmd_abort  = cfg_data[CFG_ABORT];
  assign cmd_dy     = cfg_data[CFG_DY_HI:CFG_DY_LO];
  assign cmd_dx     = cfg_data[CFG_DX_HI:CFG_DX_LO];
  assign cfg_unused = ^cfg_data[CFG_ABORT-1:CFG_DY_HI+1];

  logic start;
  logic abort;
  assign start = cfg_we && !cmd_abort && (state == IDLE);
  assign abort = cfg_we &&  cmd_abort && (state != IDLE);

  // Source ROM select
  logic [PIX_W-1:0] rom_word;
  always_comb begin
    rom_word = background_data;
    case (src_q)
      SRC_BG:   rom_word = background_data;
      SRC_CHAR: rom_word = character_data;
      SRC_CI:   rom_word = ci_data;
      SRC_WALL: rom_word = wall_data;
      default:  rom_word = background_data;
    endcase
  end

  // Destination coordinate, 10 bits so that overflow past the screen is visible
  logic [4:0] row;
  logic [4:0] col;
  logic [9:0] tgt_x;
  logic [9:0] tgt_y;
  logic       skip;
  assign row   = pix_cnt[9:5];
  assign col   = pix_cnt[4:0];
  assign tgt_x = 10'(dx_q) + 10'(col);
  assign tgt_y = 10'(dy_q) + 10'(row);
  assign skip  = (tgt_x >= SCR_W_L) || (tgt_y >= SCR_H_L) ||
                 (trans_q && (rom_word == TRANS_KEY));

  assign status = {busy_q, 20'b0, pix_cnt};

  // Blitter FSM and VRAM port arbitration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      src_q     <= SRC_BG;
      trans_q   <= 1'b0;
      dx_q      <= '0;
      dy_q      <= '0;
      pix_cnt   <= '0;
      busy_q    <= 1'b0;
      done_pend <= 1'b0;
      done      <= 1'b0;
      rom_addr  <= '0;
      vram_we   <= 1'b0;
      vram_addr <= '0;
      vram_data <= '0;
    end else begin
      vram_we   <= 1'b0;
      done      <= done_pend;
      done_pend <= 1'b0;

      if (cpu_vram_we) begin
        vram_we   <= 1'b1;
        vram_addr <= cpu_vram_addr;
        vram_data <= cpu_vram_data;
      end

      if (abort) begin
        // Write already on the port completes; nothing further is issued
        state  <= IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              src_q    <= cmd_src;
              trans_q  <= cmd_trans;
              dx_q     <= cmd_dx;
              dy_q     <= cmd_dy;
              pix_cnt  <= '0;
              rom_addr <= '0;
              busy_q   <= 1'b1;
              state    <= FETCH;
            end
          end
          FETCH: state <= WRITE;
          WRITE: begin
            // A CPU write on a visible pixel stalls here with rom_addr held
            if (skip || !cpu_vram_we) begin
              if (!skip) begin
                vram_we   <= 1'b1;
                vram_addr <= {tgt_y[COORD_W-1:0], tgt_x[COORD_W-1:0]};
                vram_data <= rom_word;
              end
              pix_cnt <= pix_cnt + CNT_W'(1);
              if (pix_cnt == LAST_PIX) begin
                state     <= IDLE;
                busy_q    <= 1'b0;
                done_pend <= 1'b1;
              end else begin
                rom_addr <= pix_cnt[ROM_AW-1:0] + ROM_AW'(1);
                state    <= FETCH;
              end
            end
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vram_blit_ctrl.sv
// Self-checking bench for vram_blit_ctrl: a tile-level reference model builds
// the expected write list per blit; every cycle the outputs are compared.
module tb_vram_blit_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [31:0] cfg_data = '0;
  logic [31:0] status;
  logic        done;
  logic        cpu_vram_we = 1'b0;
  logic [17:0] cpu_vram_addr = '0;
  logic [11:0] cpu_vram_data = '0;
  logic [9:0]  rom_addr;
  logic [11:0] background_data, character_data, ci_data, wall_data;
  logic        vram_we;
  logic [17:0] vram_addr;
  logic [11:0] vram_data;

  vram_blit_ctrl dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_data(cfg_data),
    .status(status), .done(done),
    .cpu_vram_we(cpu_vram_we), .cpu_vram_addr(cpu_vram_addr), .cpu_vram_data(cpu_vram_data),
    .rom_addr(rom_addr), .background_data(background_data), .character_data(character_data),
    .ci_data(ci_data), .wall_data(wall_data),
    .vram_we(vram_we), .vram_addr(vram_addr), .vram_data(vram_data)
  );

  always #5 clk = ~clk;

  // Sprite ROMs with one cycle read latency
  logic [11:0] rom_mem [4][1024];
  always_ff @(posedge clk) begin
    background_data <= rom_mem[0][rom_addr];
    character_data  <= rom_mem[1][rom_addr];
    ci_data         <= rom_mem[2][rom_addr];
    wall_data       <= rom_mem[3][rom_addr];
  end

  typedef struct {
    logic [17:0] addr;
    logic [11:0] data;
    int          idx;
  } wr_t;

  wr_t q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;

  bit          m_active = 0, m_aborting = 0, m_strict = 0;
  int          m_s = 0, m_done_cnt = 0, m_done_cyc = 0, m_writes = 0;
  int          m_last_idx = -1, m_last_cyc = 0;
  logic [17:0] m_last_addr = '0;
  logic [11:0] m_last_data = '0;
  bit          cpu_en = 0;
  int          force_cpu = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk_cfg(input logic [1:0] src, input bit tr, input bit ab,
                                         input logic [8:0] dx, input logic [8:0] dy);
    return {src, tr, ab, 10'b0, dy, dx};
  endfunction

  // Expected write list for a tile: row-major order, clipped and keyed pixels dropped
  task automatic start_model();
    logic [1:0] src;
    bit         tr;
    int         dx, dy;
    src = cfg_data[31:30];
    tr  = cfg_data[29];
    dy  = int'(cfg_data[17:9]);
    dx  = int'(cfg_data[8:0]);
    q.delete();
    for (int i = 0; i < 1024; i++) begin
      int x, y;
      logic [11:0] d;
      x = dx + (i % 32);
      y = dy + (i / 32);
      d = rom_mem[src][i];
      if (x < 512 && y < 480 && !(tr && d == 12'hF0F))
        q.push_back('{addr: {9'(y), 9'(x)}, data: d, idx: i});
    end
    m_active = 1; m_strict = !cpu_en; m_s = cyc;
    m_done_cnt = 0; m_writes = 0; m_last_idx = -1;
  endtask

  task automatic check_cycle();
    wr_t e;
    if (rst) begin
      chk("rst_vram_we", vram_we, 0);
      chk("rst_vram_addr", vram_addr, 0);
      chk("rst_vram_data", vram_data, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_done", done, 0);
      chk("rst_status", status, 0);
      m_active = 0; q.delete();
      return;
    end
    if (cfg_we) begin
      if (!cfg_data[28] && !m_active) start_model();
      else if (cfg_data[28] && m_active) begin
        m_active = 0; m_aborting = 1;
      end
    end
    if (cpu_vram_we) begin
      chk("cpu_we", vram_we, 1);
      chk("cpu_addr", vram_addr, cpu_vram_addr);
      chk("cpu_data", vram_data, cpu_vram_data);
      if (m_active) m_strict = 0;
    end else if (vram_we) begin
      if ((m_active || m_aborting) && q.size() > 0) begin
        e = q.pop_front();
        chk("blit_addr", vram_addr, e.addr);
        chk("blit_data", vram_data, e.data);
        if (m_strict && m_active) chk("blit_time", cyc, m_s + 2 + 2 * e.idx);
        m_writes++; m_last_idx = e.idx; m_last_cyc = cyc;
        m_last_addr = vram_addr; m_last_data = vram_data;
      end else chk("stray_we", vram_we, 0);
    end else if (m_strict && m_active && q.size() > 0 && cyc == m_s + 2 + 2 * q[0].idx) begin
      chk("blit_we_missing", vram_we, 1);
    end
    if (m_strict && m_active) begin
      chk("busy", status[31], (cyc <= m_s + 2047) ? 1 : 0);
      chk("pix_cnt", status[10:0], (cyc - m_s) / 2);
    end
    if (done) begin
      chk("done_legal", (m_active && q.size() == 0 && m_done_cnt == 0) ? 1 : 0, 1);
      if (m_strict) chk("done_time", cyc, m_s + 2049);
      if (m_last_idx == 1023) chk("done_after_last", cyc, m_last_cyc + 1);
      chk("done_status", status, 32'd1024);
      m_done_cnt++; m_done_cyc = cyc; m_active = 0;
    end else if (m_strict && m_active && cyc == m_s + 2049) begin
      chk("done_missing", done, 1);
    end
    if (m_aborting) begin
      m_aborting = 0; q.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_cycle();
    cfg_we = 1'b0;
    if (force_cpu > 0 || (cpu_en && $urandom % 6 == 0)) begin
      cpu_vram_we   = 1'b1;
      cpu_vram_addr = 18'($urandom);
      cpu_vram_data = 12'($urandom);
      if (force_cpu > 0) force_cpu--;
    end else cpu_vram_we = 1'b0;
  endtask

  task automatic start_blit(input logic [31:0] cmd);
    cfg_we = 1'b1; cfg_data = cmd;
    tick();
  endtask

  task automatic wait_pix(input int n, input int budget);
    bit found = 0;
    for (int i = 0; i < budget; i++) begin
      if (status[10:0] == 11'(n)) begin found = 1; break; end
      tick();
    end
    chk("wait_pix", found, 1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && m_done_cnt == 0; i++) tick();
    chk("done_seen", m_done_cnt, 1);
    chk("queue_drained", q.size(), 0);
    tick(); tick();
  endtask

  task automatic ramp_wall();
    for (int i = 0; i < 1024; i++) begin
      rom_mem[0][i] = 12'($urandom);
      rom_mem[1][i] = 12'($urandom);
      rom_mem[2][i] = 12'($urandom);
      rom_mem[3][i] = 12'(i);
    end
  endtask

  initial begin
    ramp_wall();
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk("idle_status", status, 0);

    // Plain ramp blit to origin
    start_blit(mk_cfg(2'd3, 0, 0, 9'd0, 9'd0));
    wait_done(2200);
    chk("ramp_writes", m_writes, 1024);
    chk("ramp_latency", m_done_cyc - m_s, 2049);
    chk("ramp_last_addr", m_last_addr, {9'd31, 9'd31});
    chk("ramp_last_data", m_last_data, 12'd1023);

    // CPU stall at pixel 10
    start_blit(mk_cfg(2'd3, 0, 0, 9'd0, 9'd0));
    wait_pix(10, 100);
    cpu_vram_we = 1'b1; cpu_vram_addr = 18'h2A5A5; cpu_vram_data = 12'h5A5;
    force_cpu = 4;
    tick();
    wait_done(2200);
    chk("stall_writes", m_writes, 1024);
    chk("stall_latency", m_done_cyc - m_s, 2053);

    // Transparent key on word 5
    rom_mem[3][5] = 12'hF0F;
    start_blit(mk_cfg(2'd3, 1, 0, 9'd0, 9'd0));
    wait_done(2200);
    chk("trans_writes", m_writes, 1023);
    chk("trans_latency", m_done_cyc - m_s, 2049);
    rom_mem[3][5] = 12'd5;

    // Clipped at bottom-right corner
    start_blit(mk_cfg(2'd3, 0, 0, 9'd500, 9'd470));
    wait_done(2200);
    chk("clip_writes", m_writes, 120);
    chk("clip_latency", m_done_cyc - m_s, 2049);
    chk("clip_last_addr", m_last_addr, {9'd479, 9'd511});

    // Start while busy is ignored
    start_blit(mk_cfg(2'd3, 0, 0, 9'd0, 9'd0));
    wait_pix(50, 200);
    start_blit(mk_cfg(2'd1, 1, 0, 9'd100, 9'd7));
    wait_done(2200);
    chk("ignore_writes", m_writes, 1024);

    // Abort at pixel 300
    start_blit(mk_cfg(2'd0, 0, 0, 9'd40, 9'd40));
    wait_pix(300, 800);
    start_blit(mk_cfg(2'd0, 0, 1, 9'd0, 9'd0));
    chk("abort_busy", status[31], 0);
    for (int i = 0; i < 60; i++) tick();
    chk("abort_no_done", m_done_cnt, 0);

    // Abort while idle has no effect
    start_blit(mk_cfg(2'd2, 0, 1, 9'd0, 9'd0));
    tick();
    chk("idle_abort_busy", status[31], 0);

    // Async reset mid-blit
    start_blit(mk_cfg(2'd3, 0, 0, 9'd0, 9'd0));
    wait_pix(100, 400);
    rst = 1'b1;
    #1;
    chk("arst_vram_we", vram_we, 0);
    chk("arst_status", status, 0);
    chk("arst_done", done, 0);
    m_active = 0; q.delete();
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    // Randomized blits with background CPU traffic
    for (int r = 0; r < 4; r++) begin
      logic [8:0] dx, dy;
      for (int s = 0; s < 4; s++)
        for (int i = 0; i < 1024; i++)
          rom_mem[s][i] = ($urandom % 16 == 0) ? 12'hF0F : 12'($urandom);
      dx = ($urandom % 2 == 1) ? 9'($urandom_range(480, 511)) : 9'($urandom % 512);
      dy = ($urandom % 2 == 1) ? 9'($urandom_range(440, 511)) : 9'($urandom % 480);
      cpu_en = 1;
      start_blit(mk_cfg(2'($urandom), 1'($urandom), 0, dx, dy));
      wait_done(9000);
      cpu_en = 0;
      tick(); tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vram_blit_ctrl.md
Name: vram_blit_ctrl

Overview:
- Tile blitter and VRAM write-port arbiter, sitting between the MIO bus and VRAM.
- Copies one 32x32 tile (1024 pixels, 12-bit RGB) from one of the four sprite ROMs (background, character, ci, wall) into VRAM at a programmed (x,y).
- The CPU programs it through a bus command register.
- CPU single-pixel VRAM writes share the single VRAM write port with the blitter; the CPU always has priority.

Parameters:
- SCREEN_W, 512, visible width in pixels; destination pixels with x >= SCREEN_W are clipped (no write).
- SCREEN_H, 480, visible height; destination pixels with y >= SCREEN_H are clipped.
- TRANS_KEY, 12'hF0F, colour treated as transparent when transparency is enabled.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  bus write strobe to the command register
- cfg_data  in  32  command: [31:30] src (0 background, 1 character, 2 ci, 3 wall); [29] transparency enable; [28] abort; [17:9] dest y; [8:0] dest x
- status  out  32  {busy, 20'b0, pix_cnt[10:0]}
- done  out  1  one-cycle pulse when a blit completes (not on abort)
- cpu_vram_we  in  1  CPU VRAM write strobe
- cpu_vram_addr  in  18  CPU VRAM address
- cpu_vram_data  in  12  CPU VRAM data
- rom_addr  out  10  address shared by all four sprite ROMs; pixel index {row[4:0], col[4:0]}
- background_data  in  12  ROM data, 1-cycle synchronous latency
- character_data  in  12  ROM data, 1-cycle synchronous latency
- ci_data  in  12  ROM data, 1-cycle synchronous latency
- wall_data  in  12  ROM data, 1-cycle synchronous latency
- vram_we  out  1  registered VRAM write strobe
- vram_addr  out  18  registered; address = {y[8:0], x[8:0]}
- vram_data  out  12  registered VRAM write data

Behaviour:
- Reset (async): state IDLE; all outputs 0 (vram_we, vram_addr, vram_data, rom_addr, done, status); command fields cleared; pix_cnt = 0.
- Command register: cfg_we in IDLE with cfg_data[28]=0 latches src, transparency enable, dx, dy; clears pix_cnt; goes to FETCH next cycle.
  - cfg_we with [28]=0 while busy: ignored.
  - cfg_we with [28]=1 while busy: abort; next state IDLE, no done pulse. A blitter write already registered still completes; no further writes.
  - cfg_we with [28]=1 in IDLE: no effect.
- FSM states:
  - IDLE: busy=0.
  - FETCH: rom_addr = pix_cnt[9:0]; always advances to WRITE.
  - WRITE: ROM data is valid. The selected ROM word is chosen by src. Target x = dx + col and y = dy + row, computed 10 bits wide with no wrap.
  - Pixel skip condition: skip the write if x >= SCREEN_W, or y >= SCREEN_H, or (transparency enabled and data == TRANS_KEY).
  - Skipped pixel: consumes the cycle; no arbitration.
  - Otherwise, if cpu_vram_we=1: stall in WRITE, holding rom_addr so the data stays valid.
  - Otherwise: issue the write and increment pix_cnt.
  - After the pixel with pix_cnt=1023 is handled: go to IDLE, and assert done for one cycle on the following cycle.
  - Otherwise: return to FETCH.
- Arbitration: CPU priority is absolute. A CPU write at cycle t appears on the vram_* outputs at t+1 unchanged. The blitter can starve under a continuous CPU write stream; this is accepted.
- Latency: pixel cost is 2 cycles unstalled, so an unclipped, opaque tile takes 2048 cycles from FETCH entry to the last write strobe.
- Output registers: vram_we is deasserted in any cycle with no write. vram_addr and vram_data hold their last value when idle.
- status.busy = (state != IDLE); status.pix_cnt counts handled pixels, 0..1024.
- Simultaneous cfg_we and cpu_vram_we: independent; both take effect.

Decomposition:
- Shared package vram_blit_pkg holds:
  - src encodings SRC_BG/SRC_CHAR/SRC_CI/SRC_WALL
  - FSM state typedef (IDLE, FETCH, WRITE)
  - cfg field bit positions
  - TILE_DIM=32
- No sub-module is needed. The ROM data mux and clip/transparency check are in-line combinational logic.

Test Plan:
- Reset → all outputs 0, busy=0. Assert rst mid-blit at pix_cnt=100 → immediate IDLE, vram_we=0, no done.
- Blit src=wall to (0,0) with a ramp ROM (data = addr) → 1024 writes with vram_addr={row,col}, data=row*32+col; done pulses once, 1 cycle after the last write; total 2048 cycles.
- Same blit with cpu_vram_we held for 5 cycles during WRITE at pix_cnt=10 → CPU writes appear first at t+1; pixel 10 is written after the stall with correct data; no pixel is lost or duplicated.
- Transparency on, ROM word 5 = 12'hF0F → pixel 5 is not written; 1023 writes total; pix_cnt ends at 1024.
- dx=500, dy=470 → only pixels with col<12 and row<10 are written (120 writes); done still pulses.
- cfg_we start while busy → ignored. cfg_we with bit 28 at pix_cnt=300 → IDLE, no done, no further vram_we from the blitter.
